id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core, with load-use hazard detection and bubble insertion.
//  Consumes the decoded control bundle and the ID-stage operands; presents them registered to EX one cycle later.
//  Drives stall_o so that the PC and IF/ID registers hold while a bubble is inserted.
//  Also counts inserted bubbles for performance measurement.
// PARAMETERS
//  DATA_W   32  operand / immediate width
//  RADDR_W  5   register-file address width
//  CNT_W    32  bubble-counter width
// PORTS
//  clk_i        in   1        clock, all state on rising edge
//  rst_i        in   1        asynchronous reset, active-low
//  start_i      in   1        core run enable; 0 -> stage loads bubbles
//  flush_i      in   1        kill ID instruction (branch/jump taken); 1 -> bubble
//  op_i         in   6        ID opcode (used for load / operand-use decode)
//  regdst_i, alusrc_i, memtoreg_i, regwrite_i, memwrite_i, memread_i  in 1 each  control bundle
//  aluop_i      in   2        ALU operation class
//  rs_data_i, rt_data_i, imm_i  in  DATA_W  register operands, sign-extended immediate
//  rs_i, rt_i, rd_i  in  RADDR_W  ID register fields
//  ex_* outputs out  (same widths)  registered copies of every input above except op_i, start_i and flush_i
//  stall_o      out  1        load-use hazard; hold PC and IF/ID this cycle
//  bubble_cnt_o out  CNT_W    number of bubbles inserted since reset
// BEHAVIOUR
//  Reset (rst_i=0, async):
//   - All ex_* outputs reset to 0; internal ex_is_load and ex_valid reset to 0.
//   - bubble_cnt_o resets to 0.
//   - stall_o reads 0 while in reset.
//  Per rising edge, priority:
//   1. start_i=0: load bubble; counter unchanged.
//   2. flush_i=1: load bubble; counter +1.
//   3. stall_o=1: load bubble; counter +1.
//   4. Otherwise: capture all inputs.
//      - ex_valid <= 1.
//      - ex_is_load <= (op_i==6'b100011).
//  Bubble definition:
//   - ex_regwrite, ex_memwrite, ex_memread, ex_valid and ex_is_load load 0.
//   - All other ex_* fields also load 0, so the output is deterministic.
//  Don't-care sanitisation:
//   - Control drives X on don't-care fields; write enables never depend on them.
//   - ex_memread is captured as memread_i & (op_i==6'b100011).
//  Hazard logic (combinational from state + ID inputs):
//   - uses_rs = op_i != 6'b000010.
//   - uses_rt = op_i in {000000, 000100, 101011}.
//   - stall_o = ex_valid & ex_is_load & (ex_rt!=0) & ((uses_rs & ex_rt==rs_i) | (uses_rt & ex_rt==rt_i)).
//  Latency and rate:
//   - Exactly 1 cycle ID->EX.
//   - A load-use stall lasts exactly 1 cycle: the bubble clears ex_is_load.
//  Simultaneous events: flush_i wins over stall_o; one bubble, counter +1 once.
//  Counter saturates at all-ones (no wrap).
//  Reset mid-stall: the bubble is discarded and stall_o drops immediately.
//  Unknown opcodes: decoded as non-load with uses_rs=1, uses_rt=0; no trap.
// STRUCTURE
//  - cpu_defs.vh: opcode localparams (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J) and ALUOp codes
//    (00 add, 01 sub, 10 funct). These are shared with the control unit and the EX stage.
//  - Sub-module hazard_detect: purely combinational uses_rs/uses_rt decode and the stall_o equation.
//  - Top level holds the pipeline register and the bubble counter.
// TESTING
//  1. Reset: assert rst_i mid-cycle with nonzero state -> all ex_* and bubble_cnt_o read 0 immediately.
//  2. Plain flow: R-type add, rs=1, rt=2, rd=3, regwrite=1, aluop=10
//     -> next edge ex_rd=3, ex_regwrite=1, stall_o=0.
//  3. Load-use: lw rt=5, then add rs=5 -> stall_o=1 for exactly 1 cycle.
//     - EX receives a bubble (ex_regwrite=0), then the add; bubble_cnt_o=1.
//  4. Non-hazards, all give stall_o=0:
//     - lw rt=0 then add rs=0.
//     - lw rt=5 then addi rt=5 (rt not used).
//     - lw rt=5 then j.
//  5. Simultaneous: load-use hazard together with flush_i=1 -> single bubble; bubble_cnt_o +1 only.
//  6. sw with memread_i=X -> ex_memread=0 and ex_is_load=0; the following add rs=rt_of_sw gives stall_o=0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared opcode and ALUOp encodings plus the decoded control bundle layout.
// Also used by the control unit and the EX stage.
package id_ex_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic is_load(input logic [5:0] op);
    return op == OP_LW;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: which source registers the ID instruction reads
// and whether the load currently in EX writes one of them.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int RADDR_W = 5
) (
  input  logic [5:0]         op_i,
  input  logic [RADDR_W-1:0] rs_i,
  input  logic [RADDR_W-1:0] rt_i,
  input  logic               ex_valid_i,
  input  logic               ex_is_load_i,
  input  logic [RADDR_W-1:0] ex_rt_i,
  output logic               stall_o
);

  logic uses_rs;
  logic uses_rt;

  always_comb begin
    uses_rs = (op_i != OP_J);
    uses_rt = (op_i == OP_RTYPE) || (op_i == OP_BEQ) || (op_i == OP_SW);
    // Writes to $zero never create a dependency.
    stall_o = ex_valid_i && ex_is_load_i && (ex_rt_i != '0) &&
              ((uses_rs && (ex_rt_i == rs_i)) || (uses_rt && (ex_rt_i == rt_i)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// count of inserted bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               flush_i,
  input  logic [5:0]         op_i,
  input  logic               regdst_i,
  input  logic               alusrc_i,
  input  logic               memtoreg_i,
  input  logic               regwrite_i,
  input  logic               memwrite_i,
  input  logic               memread_i,
  input  logic [1:0]         aluop_i,
  input  logic [DATA_W-1:0]  rs_data_i,
  input  logic [DATA_W-1:0]  rt_data_i,
  input  logic [DATA_W-1:0]  imm_i,
  input  logic [RADDR_W-1:0] rs_i,
  input  logic [RADDR_W-1:0] rt_i,
  input  logic [RADDR_W-1:0] rd_i,
  output logic               ex_regdst_o,
  output logic               ex_alusrc_o,
  output logic               ex_memtoreg_o,
  output logic               ex_regwrite_o,
  output logic               ex_memwrite_o,
  output logic               ex_memread_o,
  output logic [1:0]         ex_aluop_o,
  output logic [DATA_W-1:0]  ex_rs_data_o,
  output logic [DATA_W-1:0]  ex_rt_data_o,
  output logic [DATA_W-1:0]  ex_imm_o,
  output logic [RADDR_W-1:0] ex_rs_o,
  output logic [RADDR_W-1:0] ex_rt_o,
  output logic [RADDR_W-1:0] ex_rd_o,
  output logic               stall_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  ctrl_t              ctrl_q,    ctrl_d;
  logic [DATA_W-1:0]  rs_data_q, rs_data_d;
  logic [DATA_W-1:0]  rt_data_q, rt_data_d;
  logic [DATA_W-1:0]  imm_q,     imm_d;
  logic [RADDR_W-1:0] rs_q,      rs_d;
  logic [RADDR_W-1:0] rt_q,      rt_d;
  logic [RADDR_W-1:0] rd_q,      rd_d;
  logic               valid_q,   valid_d;
  logic               is_load_q, is_load_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               stall;
  logic               bump;

  hazard_detect #(.RADDR_W(RADDR_W)) u_hazard (
    .op_i         (op_i),
    .rs_i         (rs_i),
    .rt_i         (rt_i),
    .ex_valid_i   (valid_q),
    .ex_is_load_i (is_load_q),
    .ex_rt_i      (rt_q),
    .stall_o      (stall)
  );

  always_comb begin
    ctrl_d    = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    rs_d      = '0;
    rt_d      = '0;
    rd_d      = '0;
    valid_d   = 1'b0;
    is_load_d = 1'b0;
    bump      = 1'b0;
    if (start_i) begin
      if (flush_i || stall) begin
        bump = 1'b1;
      end else begin
        ctrl_d.regdst   = regdst_i;
        ctrl_d.alusrc   = alusrc_i;
        ctrl_d.memtoreg = memtoreg_i;
        ctrl_d.regwrite = regwrite_i;
        ctrl_d.memwrite = memwrite_i;
        // memread may be a don't-care on non-loads; only a real lw may read.
        ctrl_d.memread  = memread_i && is_load(op_i);
        ctrl_d.aluop    = aluop_i;
        rs_data_d       = rs_data_i;
        rt_data_d       = rt_data_i;
        imm_d           = imm_i;
        rs_d            = rs_i;
        rt_d            = rt_i;
        rd_d            = rd_i;
        valid_d         = 1'b1;
        is_load_d       = is_load(op_i);
      end
    end
    cnt_d = (bump && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
      is_load_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      is_load_q <= is_load_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_regdst_o   = ctrl_q.regdst;
  assign ex_alusrc_o   = ctrl_q.alusrc;
  assign ex_memtoreg_o = ctrl_q.memtoreg;
  assign ex_regwrite_o = ctrl_q.regwrite;
  assign ex_memwrite_o = ctrl_q.memwrite;
  assign ex_memread_o  = ctrl_q.memread;
  assign ex_aluop_o    = ctrl_q.aluop;
  assign ex_rs_data_o  = rs_data_q;
  assign ex_rt_data_o  = rt_data_q;
  assign ex_imm_o      = imm_q;
  assign ex_rs_o       = rs_q;
  assign ex_rt_o       = rt_q;
  assign ex_rd_o       = rd_q;
  assign stall_o       = stall;
  assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios followed by random traffic,
// all checked against a transaction-level model of the stage.
module tb_id_ex_stage;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = 4;
  localparam int BUS_W = 8 + 3 * DW + 3 * AW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i, flush_i;
  logic [5:0]    op_i;
  logic          regdst_i, alusrc_i, memtoreg_i, regwrite_i, memwrite_i, memread_i;
  logic [1:0]    aluop_i;
  logic [DW-1:0] rs_data_i, rt_data_i, imm_i;
  logic [AW-1:0] rs_i, rt_i, rd_i;
  logic          ex_regdst_o, ex_alusrc_o, ex_memtoreg_o, ex_regwrite_o, ex_memwrite_o, ex_memread_o;
  logic [1:0]    ex_aluop_o;
  logic [DW-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [AW-1:0] ex_rs_o, ex_rt_o, ex_rd_o;
  logic          stall_o;
  logic [CW-1:0] bubble_cnt_o;

  id_ex_stage #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i), .op_i(op_i),
    .regdst_i(regdst_i), .alusrc_i(alusrc_i), .memtoreg_i(memtoreg_i),
    .regwrite_i(regwrite_i), .memwrite_i(memwrite_i), .memread_i(memread_i),
    .aluop_i(aluop_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .ex_regdst_o(ex_regdst_o), .ex_alusrc_o(ex_alusrc_o), .ex_memtoreg_o(ex_memtoreg_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_memwrite_o(ex_memwrite_o), .ex_memread_o(ex_memread_o),
    .ex_aluop_o(ex_aluop_o), .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
    .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what EX should hold, plus the load tag and bubble count.
  logic [BUS_W-1:0] m_bus;
  bit               m_load;
  logic [AW-1:0]    m_rt;
  int               m_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] dut_bus();
    return {ex_regdst_o, ex_alusrc_o, ex_memtoreg_o, ex_regwrite_o, ex_memwrite_o,
            ex_memread_o, ex_aluop_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
            ex_rs_o, ex_rt_o, ex_rd_o};
  endfunction

  function automatic bit model_stall();
    bit reads_rs, reads_rt;
    reads_rs = (op_i != 6'd2);
    reads_rt = (op_i == 6'd0) || (op_i == 6'd4) || (op_i == 6'd43);
    return m_load && (m_rt != 0) && ((reads_rs && m_rt == rs_i) || (reads_rt && m_rt == rt_i));
  endfunction

  task automatic model_reset();
    m_bus  = '0;
    m_load = 0;
    m_rt   = '0;
    m_cnt  = 0;
  endtask

  task automatic set_in(input logic [5:0] op, input int rs, input int rt, input int rd,
                        input bit rw, input bit mr, input bit fl);
    op_i       = op;
    rs_i       = AW'(rs);
    rt_i       = AW'(rt);
    rd_i       = AW'(rd);
    regwrite_i = rw;
    memread_i  = mr;
    flush_i    = fl;
    regdst_i   = 1'($urandom);
    alusrc_i   = 1'($urandom);
    memtoreg_i = 1'($urandom);
    memwrite_i = (op == 6'd43);
    aluop_i    = 2'($urandom);
    rs_data_i  = $urandom;
    rt_data_i  = $urandom;
    imm_i      = $urandom;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    bit exp_stall;
    #1;
    exp_stall = model_stall();
    check("stall", stall_o, exp_stall);
    @(posedge clk_i);
    if (!start_i) begin
      m_bus = '0; m_load = 0; m_rt = '0;
    end else if (flush_i || exp_stall) begin
      m_bus = '0; m_load = 0; m_rt = '0;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else begin
      m_bus = {regdst_i, alusrc_i, memtoreg_i, regwrite_i, memwrite_i,
               memread_i && (op_i == 6'd35), aluop_i, rs_data_i, rt_data_i, imm_i,
               rs_i, rt_i, rd_i};
      m_load = (op_i == 6'd35);
      m_rt   = rt_i;
    end
    #1;
    check("ex_bus", dut_bus(), m_bus);
    check("bubble_cnt", bubble_cnt_o, m_cnt);
    @(negedge clk_i);
  endtask

  logic [5:0] ops [7] = '{6'd0, 6'd8, 6'd35, 6'd43, 6'd4, 6'd2, 6'd17};

  initial begin
    rst_i = 1'b0; start_i = 1'b0;
    set_in(6'd0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check("reset_bus", dut_bus(), '0);
    check("reset_cnt", bubble_cnt_o, 0);
    check("reset_stall", stall_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1;

    // Plain R-type flow
    set_in(6'd0, 1, 2, 3, 1, 0, 0); aluop_i = 2'b10; step();
    check("t2_rd", ex_rd_o, 3);
    check("t2_regwrite", ex_regwrite_o, 1);

    // Load-use: one bubble, then the add
    set_in(6'd35, 4, 5, 0, 1, 1, 0); step();
    set_in(6'd0, 5, 6, 7, 1, 0, 0);
    #1 check("t3_stall_hi", stall_o, 1);
    step();
    check("t3_bubble_rw", ex_regwrite_o, 0);
    check("t3_stall_lo", stall_o, 0);
    step();
    check("t3_rd", ex_rd_o, 7);
    check("t3_cnt", bubble_cnt_o, 1);

    // Non-hazards
    set_in(6'd35, 1, 0, 0, 1, 1, 0); step();
    set_in(6'd0, 0, 0, 3, 1, 0, 0);
    #1 check("t4_zero", stall_o, 0);
    step();
    set_in(6'd35, 1, 5, 0, 1, 1, 0); step();
    set_in(6'd8, 1, 5, 0, 1, 0, 0);
    #1 check("t4_addi", stall_o, 0);
    step();
    set_in(6'd35, 1, 5, 0, 1, 1, 0); step();
    set_in(6'd2, 5, 5, 0, 0, 0, 0);
    #1 check("t4_j", stall_o, 0);
    step();

    // Hazard together with flush: a single bubble
    set_in(6'd35, 1, 5, 0, 1, 1, 0); step();
    set_in(6'd0, 5, 2, 3, 1, 0, 1);
    step();
    check("t5_cnt", bubble_cnt_o, 2);
    set_in(6'd0, 5, 2, 3, 1, 0, 0); step();

    // Store with stray memread must not look like a load
    set_in(6'd43, 1, 9, 0, 0, 1, 0); step();
    check("t6_memread", ex_memread_o, 0);
    set_in(6'd0, 9, 1, 2, 1, 0, 0);
    #1 check("t6_stall", stall_o, 0);
    step();

    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 300; i++) begin
      start_i = ($urandom_range(0, 15) != 0);
      set_in(ops[$urandom_range(0, 6)], $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 31), 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
      step();
    end

    // Saturation
    start_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_in(6'd0, 1, 2, 3, 1, 0, 1);
      step();
    end
    check("sat_cnt", bubble_cnt_o, (1 << CW) - 1);

    // Reset while a stall is pending
    set_in(6'd35, 1, 6, 0, 1, 1, 0); step();
    set_in(6'd0, 6, 1, 2, 1, 0, 0);
    #1 check("rst_pre_stall", stall_o, 1);
    rst_i = 1'b0;
    #1;
    model_reset();
    check("rst_stall", stall_o, 0);
    check("rst_bus", dut_bus(), '0);
    check("rst_cnt", bubble_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
